// File: rtl/scan_seq_3b_pkg.sv
// Shared types and defaults for the scan sequencer.
// SCAN_SEQ_BLANK_EN adds the BLANK state.
package scan_seq_3b_pkg;

  localparam int DEF_DIV    = 4;
  localparam int DEF_NUM_CH = 8;

`ifdef SCAN_SEQ_BLANK_EN
  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_SCAN  = 2'd1,
    ST_BLANK = 2'd2
  } state_t;
`else
  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_SCAN = 2'd1
  } state_t;
`endif

endpackage

// File: rtl/scan_seq_3b_prescaler.sv
// Dwell prescaler: counts 0..DIV-1 while enabled, tick on DIV-1.
// Unaffected by SCAN_SEQ_BLANK_EN.
module scan_prescaler #(
  parameter int DIV = 4
) (
  input  logic clk,
  input  logic rst,
  input  logic clr,
  input  logic en,
  output logic tick
);

  localparam int CW = (DIV > 1) ? $clog2(DIV) : 1;
  localparam logic [CW-1:0] LAST = CW'(DIV - 1);
  localparam logic [CW-1:0] ONE  = CW'(1);

  logic [CW-1:0] cnt;

  assign tick = en && (cnt == LAST);

  always_ff @(posedge clk or posedge rst) begin
    if (rst)
      cnt <= '0;
    else if (clr)
      cnt <= '0;
    else if (en)
      cnt <= tick ? '0 : cnt + ONE;
  end

endmodule

// File: rtl/scan_seq_3b.sv
// Channel scan sequencer feeding a 3-to-8 decoder (x, En).
// Define SCAN_SEQ_BLANK_EN for a DIV-cycle dark gap between channels.
module scan_seq_3b
  import scan_seq_3b_pkg::*;
#(
  parameter int DIV    = DEF_DIV,
  parameter int NUM_CH = DEF_NUM_CH
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       start,
  input  logic       stop,
  input  logic       cont,
  output logic [2:0] x,
  output logic       En,
  output logic       busy,
  output logic       done
);

  localparam logic [2:0] LAST_CH = 3'(NUM_CH - 1);

  state_t state;
  logic   tick;

  assign busy = (state != ST_IDLE);

  scan_prescaler #(.DIV(DIV)) u_pre (
    .clk  (clk),
    .rst  (rst),
    .clr  (stop || !busy),
    .en   (busy),
    .tick (tick)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= ST_IDLE;
      x     <= '0;
      En    <= 1'b0;
      done  <= 1'b0;
    end else begin
      done <= 1'b0;
      if (stop) begin
        state <= ST_IDLE;
        x     <= '0;
        En    <= 1'b0;
      end else begin
        case (state)
          ST_IDLE: begin
            if (start) begin
              state <= ST_SCAN;
              x     <= '0;
              En    <= 1'b1;
            end
          end
          ST_SCAN: begin
            if (tick) begin
              if (x == LAST_CH) begin
                x <= '0;
                if (!cont) begin
                  state <= ST_IDLE;
                  En    <= 1'b0;
                  done  <= 1'b1;
                end
              end else begin
`ifdef SCAN_SEQ_BLANK_EN
                // go dark first; x advances at the end of the gap
                state <= ST_BLANK;
                En    <= 1'b0;
`else
                x <= x + 3'd1;
`endif
              end
            end
          end
`ifdef SCAN_SEQ_BLANK_EN
          ST_BLANK: begin
            if (tick) begin
              state <= ST_SCAN;
              x     <= x + 3'd1;
              En    <= 1'b1;
            end
          end
`endif
          default: begin
            state <= ST_IDLE;
            x     <= '0;
            En    <= 1'b0;
          end
        endcase
      end
    end
  end

endmodule

// File: tb/tb_scan_seq_3b.sv
// Bench for scan_seq_3b; frame-position reference model.
// Honours SCAN_SEQ_BLANK_EN when defined.
module tb_scan_seq_3b;

  localparam int D = 4;
  localparam int N = 8;
`ifdef SCAN_SEQ_BLANK_EN
  localparam int FR = (2 * N - 1) * D;
`else
  localparam int FR = N * D;
`endif

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic start = 1'b0, stop = 1'b0, cont = 1'b0;
  logic start1 = 1'b0, stop1 = 1'b0, cont1 = 1'b0;
  logic [2:0] x, x1;
  logic en_o, en1, busy, busy1, done, done1;

  always #5 clk = ~clk;

  scan_seq_3b #(.DIV(D), .NUM_CH(N)) dut (
    .clk(clk), .rst(rst), .start(start), .stop(stop), .cont(cont),
    .x(x), .En(en_o), .busy(busy), .done(done)
  );

  scan_seq_3b #(.DIV(1), .NUM_CH(1)) dut1 (
    .clk(clk), .rst(rst), .start(start1), .stop(stop1), .cont(cont1),
    .x(x1), .En(en1), .busy(busy1), .done(done1)
  );

  logic [7:0] y;
  logic [7:0] one8 = 8'h01;
  assign y = en_o ? (one8 << x) : 8'h00;
  wire [13:0] got = {x, en_o, busy, done, y};

  int n_chk = 0;
  int n_fail = 0;

  // model: active flag and position within the frame (cycles since start)
  bit m_act = 0;
  int m_pos = 0;
  bit m_done = 0;

  function automatic logic [2:0] exp_x();
    int slot;
    slot = m_pos / D;
    if (!m_act) return 3'd0;
`ifdef SCAN_SEQ_BLANK_EN
    return 3'(slot / 2);
`else
    return 3'(slot);
`endif
  endfunction

  function automatic logic exp_en();
    if (!m_act) return 1'b0;
`ifdef SCAN_SEQ_BLANK_EN
    return ((m_pos / D) % 2) == 0;
`else
    return 1'b1;
`endif
  endfunction

  function automatic logic [13:0] exp_vec();
    logic [2:0] ex;
    logic ee;
    logic [7:0] ey;
    ex = exp_x();
    ee = exp_en();
    ey = ee ? (one8 << ex) : 8'h00;
    return {ex, ee, m_act, m_done, ey};
  endfunction

  task automatic model_reset();
    m_act = 0; m_pos = 0; m_done = 0;
  endtask

  task automatic model_step(input bit st, input bit sp, input bit ct);
    m_done = 0;
    if (sp) begin
      m_act = 0; m_pos = 0;
    end else if (!m_act) begin
      if (st) begin m_act = 1; m_pos = 0; end
    end else if (m_pos == FR - 1) begin
      m_pos = 0;
      if (!ct) begin m_act = 0; m_done = 1; end
    end else begin
      m_pos++;
    end
  endtask

  task automatic cyc();
    @(posedge clk);
    model_step(start, stop, cont);
    @(negedge clk);
  endtask

  task automatic test_reset();
    bit found;
    @(negedge clk);
    n_chk++;
    if ({x, en_o, busy, done} !== 6'd0) begin
      n_fail++;
      $display("FAIL reset_hold got=%h exp=00", {x, en_o, busy, done});
    end
    rst = 1'b0;
    model_reset();
    start = 1'b1;
    cyc();
    start = 1'b0;
    found = 0;
    for (int i = 0; i < FR && !found; i++) begin
      if (exp_x() == 3'd5 && exp_en()) found = 1;
      else cyc();
    end
    n_chk++;
    if (!found || got !== exp_vec()) begin
      n_fail++;
      $display("FAIL reset_reach_x5 found=%0d got=%h exp=%h", found, got, exp_vec());
    end
    #2 rst = 1'b1;
    #1;
    n_chk++;
    if (got !== 14'd0) begin
      n_fail++;
      $display("FAIL reset_async got=%h exp=0000", got);
    end
    @(negedge clk);
    rst = 1'b0;
    model_reset();
    n_chk++;
    if (got !== exp_vec()) begin
      n_fail++;
      $display("FAIL reset_release got=%h exp=%h", got, exp_vec());
    end
  endtask

  task automatic test_single_shot();
    int en_cnt, busy_cnt, done_cnt;
    en_cnt = 0; busy_cnt = 0; done_cnt = 0;
    cont = 1'b0;
    start = 1'b1;
    cyc();
    start = 1'b0;
    n_chk++;
    if (en_o !== 1'b1 || x !== 3'd0) begin
      n_fail++;
      $display("FAIL single_first got En=%b x=%0d exp En=1 x=0", en_o, x);
    end
    for (int i = 0; i < FR + 4; i++) begin
      n_chk++;
      if (got !== exp_vec()) begin
        n_fail++;
        $display("FAIL single i=%0d got=%h exp=%h", i, got, exp_vec());
      end
      en_cnt += int'(en_o);
      busy_cnt += int'(busy);
      done_cnt += int'(done);
      cyc();
    end
    n_chk++;
    if (en_cnt != N * D || busy_cnt != FR || done_cnt != 1) begin
      n_fail++;
      $display("FAIL single_counts got en=%0d busy=%0d done=%0d exp %0d %0d 1",
               en_cnt, busy_cnt, done_cnt, N * D, FR);
    end
  endtask

  task automatic test_continuous();
    int done_cnt;
    bit found;
    done_cnt = 0;
    cont = 1'b1;
    start = 1'b1;
    cyc();
    start = 1'b0;
    for (int i = 0; i < 2 * FR + 3; i++) begin
      n_chk++;
      if (got !== exp_vec()) begin
        n_fail++;
        $display("FAIL cont i=%0d got=%h exp=%h", i, got, exp_vec());
      end
      done_cnt += int'(done);
      cyc();
    end
    n_chk++;
    if (done_cnt != 0 || busy !== 1'b1) begin
      n_fail++;
      $display("FAIL cont_nodone got done=%0d busy=%b exp 0 1", done_cnt, busy);
    end
    found = 0;
    for (int i = 0; i < 2 * FR && !found; i++) begin
      if (exp_x() == 3'(N - 1) && exp_en()) found = 1;
      else cyc();
    end
    cont = 1'b0;
    for (int i = 0; i < D + 3; i++) begin
      n_chk++;
      if (got !== exp_vec()) begin
        n_fail++;
        $display("FAIL cont_drop i=%0d got=%h exp=%h", i, got, exp_vec());
      end
      done_cnt += int'(done);
      cyc();
    end
    n_chk++;
    if (!found || done_cnt != 1 || busy !== 1'b0) begin
      n_fail++;
      $display("FAIL cont_end found=%0d got done=%0d busy=%b exp 1 0",
               found, done_cnt, busy);
    end
  endtask

  task automatic test_abort();
    bit found;
    int en_cnt;
    en_cnt = 0;
    cont = 1'b0;
    start = 1'b1;
    cyc();
    start = 1'b0;
    found = 0;
    for (int i = 0; i < FR && !found; i++) begin
      if (exp_x() == 3'd3 && exp_en() && (m_pos % D) == 2) found = 1;
      else cyc();
    end
    stop = 1'b1;
    cyc();
    stop = 1'b0;
    n_chk++;
    if (!found || {x, en_o, busy, done} !== 6'd0 || got !== exp_vec()) begin
      n_fail++;
      $display("FAIL abort found=%0d got=%h exp=%h", found, got, exp_vec());
    end
    start = 1'b1;
    cyc();
    start = 1'b0;
    for (int i = 0; i < FR + 2; i++) begin
      n_chk++;
      if (got !== exp_vec()) begin
        n_fail++;
        $display("FAIL abort_restart i=%0d got=%h exp=%h", i, got, exp_vec());
      end
      en_cnt += int'(en_o);
      cyc();
    end
    n_chk++;
    if (en_cnt != N * D) begin
      n_fail++;
      $display("FAIL abort_len got=%0d exp=%0d", en_cnt, N * D);
    end
  endtask

  task automatic test_priority();
    start = 1'b1;
    stop = 1'b1;
    cyc();
    start = 1'b0;
    stop = 1'b0;
    n_chk++;
    if (busy !== 1'b0 || en_o !== 1'b0) begin
      n_fail++;
      $display("FAIL prio_start_stop got busy=%b En=%b exp 0 0", busy, en_o);
    end
    start = 1'b1;
    cyc();
    for (int i = 0; i < FR + 3; i++) begin
      start = 1'($urandom_range(1));
      if (i >= FR - 2) start = 1'b0;
      n_chk++;
      if (got !== exp_vec()) begin
        n_fail++;
        $display("FAIL prio_busy_start i=%0d got=%h exp=%h", i, got, exp_vec());
      end
      cyc();
    end
    start = 1'b0;
  endtask

  task automatic test_random();
    for (int i = 0; i < 600; i++) begin
      start = ($urandom_range(7) == 0);
      stop = ($urandom_range(59) == 0);
      cont = 1'($urandom_range(1));
      cyc();
      n_chk++;
      if (got !== exp_vec()) begin
        n_fail++;
        $display("FAIL random i=%0d got=%h exp=%h", i, got, exp_vec());
      end
    end
    start = 1'b0;
    stop = 1'b0;
    cont = 1'b0;
  endtask

  task automatic test_ch1();
    logic [3:0] seq [4];
    seq[0] = 4'b0110;
    seq[1] = 4'b0001;
    seq[2] = 4'b0000;
    seq[3] = 4'b0000;
    start1 = 1'b1;
    @(negedge clk);
    start1 = 1'b0;
    for (int i = 0; i < 4; i++) begin
      n_chk++;
      if ({x1, en1, busy1, done1} !== {3'd0, seq[i][2:0]} ||
          (i == 0 && x1 !== 3'd0)) begin
        n_fail++;
        $display("FAIL ch1 i=%0d got x=%0d En=%b busy=%b done=%b exp x=0 %b",
                 i, x1, en1, busy1, done1, seq[i][2:0]);
      end
      @(negedge clk);
    end
    cont1 = 1'b1;
    start1 = 1'b1;
    @(negedge clk);
    start1 = 1'b0;
    for (int i = 0; i < 5; i++) begin
      n_chk++;
      if ({x1, en1, busy1, done1} !== 6'b000_110) begin
        n_fail++;
        $display("FAIL ch1_cont i=%0d got=%b exp=000110", i, {x1, en1, busy1, done1});
      end
      @(negedge clk);
    end
    stop1 = 1'b1;
    @(negedge clk);
    stop1 = 1'b0;
    cont1 = 1'b0;
    n_chk++;
    if ({x1, en1, busy1, done1} !== 6'd0) begin
      n_fail++;
      $display("FAIL ch1_stop got=%b exp=000000", {x1, en1, busy1, done1});
    end
  endtask

  initial begin
    test_reset();
    test_single_shot();
    test_continuous();
    test_abort();
    test_priority();
    test_random();
    test_ch1();
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
